// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared types and helpers for the fetch-stage branch predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t CTR_RESET = WNT;
    localparam bp_ctr_t CTR_ALLOC = WT;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
        bp_ctr_t n;
        n = c;
        unique case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = CTR_RESET;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_predictor
//  Description : Direct-mapped BTB with 2-bit saturating counters, looked up
//                combinationally from the fetch PC and trained from execute.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ENTRIES  = 64,
    parameter int PC_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_tbl,
    input  logic [WIDTH-1:0] pc_f,
    output logic             predict_taken,
    output logic [WIDTH-1:0] predict_target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [WIDTH-1:0] upd_target,
    output logic [31:0]      hit_count
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = WIDTH - PC_SHIFT - IDXW;

    logic              r_valid  [ENTRIES];
    bp_ctr_t           r_ctr    [ENTRIES];
    logic [TAGW-1:0]   r_tag    [ENTRIES];
    logic [WIDTH-1:0]  r_target [ENTRIES];
    logic [31:0]       r_hit_count;

    logic [IDXW-1:0]   w_f_idx;
    logic [TAGW-1:0]   w_f_tag;
    logic [IDXW-1:0]   w_u_idx;
    logic [TAGW-1:0]   w_u_tag;
    logic              w_hit;
    logic              w_upd_hit;
    logic              w_unused_lsb;

    assign w_f_idx = pc_f[PC_SHIFT +: IDXW];
    assign w_f_tag = pc_f[WIDTH-1 -: TAGW];
    assign w_u_idx = upd_pc[PC_SHIFT +: IDXW];
    assign w_u_tag = upd_pc[WIDTH-1 -: TAGW];

    // Instruction-alignment bits take no part in indexing or tagging.
    generate
        if (PC_SHIFT > 0) begin : g_lsb
            assign w_unused_lsb = ^{pc_f[PC_SHIFT-1:0], upd_pc[PC_SHIFT-1:0]};
        end else begin : g_no_lsb
            assign w_unused_lsb = 1'b0;
        end
    endgenerate

    // Lookup sees the pre-update table; no write-to-read bypass.
    assign w_hit          = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign predict_taken  = w_hit && r_ctr[w_f_idx][1];
    assign predict_target = w_hit ? r_target[w_f_idx] : '0;
    assign hit_count      = r_hit_count;

    assign w_upd_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_RESET;
            end
        end else if (flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_u_idx] <= bp_ctr_next(r_ctr[w_u_idx], upd_taken);
            end else if (upd_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_ctr[w_u_idx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag/target payload is only meaningful behind a valid bit, so it is not reset.
    always_ff @(posedge clk) begin
        if (!flush_tbl && upd_valid && upd_taken) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count <= '0;
        end else if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_predictor
//  Description : Directed self-checking bench for branch_target_predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    logic        clk;
    logic        reset;
    logic        flush_tbl;
    logic [31:0] pc_f;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] hit_count;

    int          n_cmp;
    int          n_err;
    logic        exp_hit;
    logic [31:0] exp_hc;

    branch_target_predictor #(
        .WIDTH    (32),
        .ENTRIES  (64),
        .PC_SHIFT (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_tbl      (flush_tbl),
        .pc_f           (pc_f),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .hit_count      (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Expected hit counter advances on every edge where the lookup is expected to hit.
    task automatic tick();
        if (exp_hit) exp_hc = exp_hc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        pc_f = pc;
        settle();
        check({tag, ".taken"},  {31'd0, predict_taken}, {31'd0, t});
        check({tag, ".target"}, predict_target, tgt);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_hit    = 1'b0;
        exp_hc     = 32'd0;
        reset      = 1'b1;
        flush_tbl  = 1'b0;
        pc_f       = 32'h100;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // 1: reset state
        lookup("reset", 32'h100, 1'b0, 32'h0);
        check("reset.hit_count", hit_count, 32'd0);

        // 5 + 2: allocate while looking up the same PC; old state visible this cycle
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_target = 32'h200;
        settle();
        check("same_cycle.taken", {31'd0, predict_taken}, 32'd0);
        tick();
        upd_valid = 1'b0;
        exp_hit   = 1'b1;
        lookup("alloc", 32'h100, 1'b1, 32'h200);
        check("alloc.hit_count0", hit_count, 32'd0);
        tick();
        check("alloc.hit_count1", hit_count, 32'd1);

        // 3: two not-taken -> 10->01->00, entry still hits
        upd_valid = 1'b1;
        upd_taken = 1'b0;
        tick();
        lookup("nt1", 32'h100, 1'b0, 32'h200);
        tick();
        lookup("nt2", 32'h100, 1'b0, 32'h200);
        tick();
        lookup("nt3_sat", 32'h100, 1'b0, 32'h200);
        check("nt.hit_count", hit_count, exp_hc);

        // taken updates from 00 with a new target: 01,10,11,11,11
        upd_taken  = 1'b1;
        upd_target = 32'h240;
        tick();
        lookup("t1", 32'h100, 1'b0, 32'h240);
        tick();
        lookup("t2", 32'h100, 1'b1, 32'h240);
        tick();
        tick();
        tick();
        lookup("t5", 32'h100, 1'b1, 32'h240);
        // saturated at 11: one not-taken still predicts taken, second does not
        upd_taken = 1'b0;
        tick();
        lookup("st_nt1", 32'h100, 1'b1, 32'h240);
        tick();
        lookup("st_nt2", 32'h100, 1'b0, 32'h240);
        check("train.hit_count", hit_count, exp_hc);

        // 4: alias at index 0 with a different tag replaces the entry
        upd_pc     = 32'h200;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        tick();
        upd_valid = 1'b0;
        exp_hit   = 1'b0;
        lookup("alias.old", 32'h100, 1'b0, 32'h0);
        exp_hit   = 1'b1;
        lookup("alias.new", 32'h200, 1'b1, 32'h300);
        tick();
        check("alias.hit_count", hit_count, exp_hc);

        // not-taken miss never allocates
        upd_valid = 1'b1;
        upd_pc    = 32'h404;
        upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        exp_hit   = 1'b0;
        lookup("nt_miss", 32'h404, 1'b0, 32'h0);
        tick();
        check("nt_miss.hit_count", hit_count, exp_hc);

        // 6: flush wins over a simultaneous taken update
        exp_hit    = 1'b1;
        pc_f       = 32'h200;
        flush_tbl  = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h404;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        tick();
        flush_tbl = 1'b0;
        upd_valid = 1'b0;
        exp_hit   = 1'b0;
        lookup("flush.a", 32'h200, 1'b0, 32'h0);
        lookup("flush.b", 32'h404, 1'b0, 32'h0);
        tick();
        tick();
        check("flush.hit_count", hit_count, exp_hc);

        // reset asserted during an update: update lost, count cleared asynchronously
        upd_valid  = 1'b1;
        upd_pc     = 32'h100;
        upd_taken  = 1'b1;
        upd_target = 32'h600;
        pc_f       = 32'h100;
        reset      = 1'b1;
        settle();
        check("async_reset.hit_count", hit_count, 32'd0);
        exp_hc = 32'd0;
        tick();
        reset     = 1'b0;
        upd_valid = 1'b0;
        lookup("reset_mid_upd", 32'h100, 1'b0, 32'h0);
        tick();
        check("reset_mid_upd.hit_count", hit_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
